// File: rtl/watch_time_ctrl.sv
// watch_time_ctrl
//   Timekeeping and set-mode controller for the digital watch. Advances
//   HH:MM:SS on the 1 Hz timer_tick and lets the user set hours and minutes
//   through a RUN -> SET_HOUR -> SET_MIN -> RUN mode cycle.
//
// Ports
//   clk_in      in   system clock
//   rst         in   synchronous, active-high reset (wins over every input)
//   timer_tick  in   1-cycle pulse, once per second
//   btn_mode    in   1-cycle debounced pulse, advances the mode
//   btn_inc     in   1-cycle debounced pulse, increments the field being set
//   hours       out  current hour, 0..HOUR_MAX
//   minutes     out  current minute, 0..MIN_MAX
//   seconds     out  current second, 0..MIN_MAX
//   mode        out  0=RUN, 1=SET_HOUR, 2=SET_MIN (also the FSM state for debug)
//   blink       out  field-blink enable for the display, 0 in RUN
//   day_tick    out  1-cycle pulse on the HOUR_MAX:MIN_MAX:MIN_MAX rollover
//
// Inputs are plain 1-cycle pulses (no valid/ready handshake): a pulse is
// consumed in the cycle it is high, and its effect is visible on the
// registered outputs in the following cycle.

module watch_time_ctrl #(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       timer_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hours,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic [1:0] mode,
    output logic       blink,
    output logic       day_tick
);

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_ILLEGAL  = 2'd3
    } mode_t;

    localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MAX);

    mode_t      mode_q, mode_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;
    logic       day_tick_q, day_tick_d;

    always_comb begin
        mode_d     = mode_q;
        hours_d    = hours_q;
        minutes_d  = minutes_q;
        seconds_d  = seconds_q;
        blink_d    = blink_q;
        day_tick_d = 1'b0;

        case (mode_q)
            MODE_RUN: begin
                // A tick coinciding with btn_mode is still applied, carries included.
                if (timer_tick) begin
                    if (seconds_q == MIN_LAST) begin
                        seconds_d = 6'd0;
                        if (minutes_q == MIN_LAST) begin
                            minutes_d = 6'd0;
                            if (hours_q == HOUR_LAST) begin
                                hours_d    = 5'd0;
                                day_tick_d = 1'b1;
                            end else begin
                                hours_d = hours_q + 5'd1;
                            end
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
                if (btn_mode) begin
                    mode_d  = MODE_SET_HOUR;
                    blink_d = 1'b1;
                end
            end

            MODE_SET_HOUR: begin
                // Time is frozen while setting; the tick only drives the blink.
                if (timer_tick) blink_d = ~blink_q;
                if (btn_inc) hours_d = (hours_q == HOUR_LAST) ? 5'd0 : hours_q + 5'd1;
                // Blink value carries over into SET_MIN unchanged.
                if (btn_mode) mode_d = MODE_SET_MIN;
            end

            MODE_SET_MIN: begin
                if (timer_tick) blink_d = ~blink_q;
                // Minute wrap is deliberately carry-free into hours.
                if (btn_inc) minutes_d = (minutes_q == MIN_LAST) ? 6'd0 : minutes_q + 6'd1;
                if (btn_mode) begin
                    mode_d    = MODE_RUN;
                    seconds_d = 6'd0;
                    blink_d   = 1'b0;
                end
            end

            default: begin
                // Unreachable encoding: recover to RUN with blink off.
                mode_d  = MODE_RUN;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            mode_q     <= MODE_RUN;
            hours_q    <= 5'd0;
            minutes_q  <= 6'd0;
            seconds_q  <= 6'd0;
            blink_q    <= 1'b0;
            day_tick_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            blink_q    <= blink_d;
            day_tick_q <= day_tick_d;
        end
    end

    assign hours    = hours_q;
    assign minutes  = minutes_q;
    assign seconds  = seconds_q;
    assign mode     = mode_q;
    assign blink    = blink_q;
    assign day_tick = day_tick_q;

endmodule

// File: tb/tb_watch_time_ctrl.sv
// tb_watch_time_ctrl
//   Drives watch_time_ctrl with directed scenarios followed by randomized
//   pulses, comparing every output each cycle against a reference model
//   that keeps time as a single seconds-of-day count.

module tb_watch_time_ctrl;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SPM = MIN_MAX + 1;            // seconds per minute
    localparam int SPH = SPM * SPM;              // seconds per hour
    localparam int SPD = SPH * (HOUR_MAX + 1);   // seconds per day

    // ---------------- clock / reset ----------------
    logic       clk_in = 1'b0;
    logic       rst = 1'b0;
    logic       timer_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;
    logic       day_tick;

    always #5 clk_in = ~clk_in;

    watch_time_ctrl #(.HOUR_MAX(HOUR_MAX), .MIN_MAX(MIN_MAX)) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .timer_tick (timer_tick),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .mode       (mode),
        .blink      (blink),
        .day_tick   (day_tick)
    );

    // ---------------- reference model ----------------
    int tod;       // seconds since midnight
    int m_mode;    // 0 RUN, 1 SET_HOUR, 2 SET_MIN
    int m_blink;
    int m_day;

    function automatic int m_h();
        return tod / SPH;
    endfunction
    function automatic int m_m();
        return (tod / SPM) % SPM;
    endfunction
    function automatic int m_s();
        return tod % SPM;
    endfunction

    task automatic model_step(input logic r, input logic t, input logic bm, input logic bi);
        int h, m, s;
        if (r) begin
            tod = 0; m_mode = 0; m_blink = 0; m_day = 0;
            return;
        end
        m_day = 0;
        h = m_h(); m = m_m(); s = m_s();
        case (m_mode)
            0: begin
                if (t) begin
                    tod = (tod + 1) % SPD;
                    m_day = (tod == 0) ? 1 : 0;
                end
                if (bm) begin m_mode = 1; m_blink = 1; end
            end
            1: begin
                if (t) m_blink = 1 - m_blink;
                if (bi) tod = ((h + 1) % (HOUR_MAX + 1)) * SPH + m * SPM + s;
                if (bm) m_mode = 2;
            end
            default: begin
                if (t) m_blink = 1 - m_blink;
                if (bi) tod = h * SPH + ((m + 1) % SPM) * SPM + s;
                if (bm) begin m_mode = 0; tod = tod - s; m_blink = 0; end
            end
        endcase
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("hours",    32'(hours),    32'(m_h()));
        check("minutes",  32'(minutes),  32'(m_m()));
        check("seconds",  32'(seconds),  32'(m_s()));
        check("mode",     32'(mode),     32'(m_mode));
        check("blink",    32'(blink),    32'(m_blink));
        check("day_tick", 32'(day_tick), 32'(m_day));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic t, input logic bm, input logic bi);
        @(negedge clk_in);
        rst = r; timer_tick = t; btn_mode = bm; btn_inc = bi;
        @(posedge clk_in);
        #1;
        model_step(r, t, bm, bi);
        compare_all();
        @(negedge clk_in);
        rst = 1'b0; timer_tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    // From RUN: set hours and minutes through set mode, then tick up seconds.
    task automatic set_time(input int h, input int m, input int s);
        int nh, nm;
        nh = (h - m_h() + HOUR_MAX + 1) % (HOUR_MAX + 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < nh; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        nm = (m - m_m() + SPM) % SPM;
        for (int i = 0; i < nm; i++) step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        for (int i = 0; i < s; i++) step(0, 1, 0, 0);
    endtask

    initial begin
        tod = 0; m_mode = 0; m_blink = 0; m_day = 0;

        // 1. reset, then 60 ticks
        step(1, 1, 1, 1);
        for (int i = 0; i < 60; i++) step(0, 1, 0, 0);
        check("t1_min", 32'(minutes), 32'd1);
        check("t1_sec", 32'(seconds), 32'd0);

        // 2. preload 23:59:58, two ticks roll the day
        set_time(23, 59, 58);
        step(0, 1, 0, 0);
        check("t2_no_day_early", 32'(day_tick), 32'd0);
        step(0, 1, 0, 0);
        check("t2_day_tick", 32'(day_tick), 32'd1);
        check("t2_hours_zero", 32'(hours), 32'd0);
        step(0, 0, 0, 0);
        check("t2_day_tick_drop", 32'(day_tick), 32'd0);

        // 3. SET_HOUR, 25 increments with interleaved ticks
        step(0, 0, 1, 0);
        for (int i = 0; i < 25; i++) begin
            step(0, 0, 0, 1);
            step(0, 1, 0, 0);
        end
        check("t3_hours_wrap", 32'(hours), 32'd1);
        check("t3_sec_frozen", 32'(seconds), 32'd0);

        // 4. SET_MIN at 59 wraps without carry; exit clears seconds/blink
        step(0, 0, 1, 0);
        for (int i = 0; i < 59; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("t4_min_wrap", 32'(minutes), 32'd0);
        check("t4_no_carry", 32'(hours), 32'd1);
        step(0, 1, 1, 0);
        check("t4_mode_run", 32'(mode), 32'd0);
        check("t4_blink_off", 32'(blink), 32'd0);

        // 5. tick + btn_mode at 00:00:59
        set_time(0, 0, 59);
        step(0, 1, 1, 0);
        check("t5_min", 32'(minutes), 32'd1);
        check("t5_sec", 32'(seconds), 32'd0);
        check("t5_mode", 32'(mode), 32'd1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        // 6. reset mid-set at 12:34:xx, then increments do nothing
        set_time(12, 34, 7);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(1, 1, 1, 1);
        check("t6_hours", 32'(hours), 32'd0);
        check("t6_mode", 32'(mode), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("t6_inc_ignored", 32'(minutes), 32'd0);

        // random phase
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
